// File: rtl/lsu_mem_requester_if.sv
// LSU bundle: pipeline request/response handshake plus the data-memory port.
// master = LSU view (drives memory, answers requests); slave = pipeline/memory view.
interface lsu_mem_requester_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ena;
  logic        mem_wr_en;
  logic [1:0]  mem_wr_sel;
  logic [1:0]  mem_rd_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_ena, mem_wr_en, mem_wr_sel, mem_rd_sel, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_ena, mem_wr_en, mem_wr_sel, mem_rd_sel, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_requester.sv
// Load/store initiator: aligned ops take one memory access, misaligned ones split into bytes.
// Latency accept->resp: 2 aligned, N+1 split, 1 error; req_ready only while idle (one op in flight).
module lsu_mem_requester #(
  parameter logic [31:0] MEM_BASE         = 32'h1001_0000,
  parameter int unsigned MEM_BYTES        = 4096,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic          clk_sig,
  input  logic          rst_sig,
  lsu_mem_requester_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_e;

  localparam logic [32:0] WIN_LO = {1'b0, MEM_BASE};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(MEM_BYTES);

  function automatic logic [2:0] op_size(input logic [2:0] op);
    logic [2:0] s;
    case (op)
      3'd0, 3'd1, 3'd5: s = 3'd1;
      3'd2, 3'd3, 3'd6: s = 3'd2;
      default:          s = 3'd4;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] op, input logic err,
                                         input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (!err) begin
      case (op)
        3'd0:    r = {{24{a[7]}}, a[7:0]};
        3'd1:    r = {24'd0, a[7:0]};
        3'd2:    r = {{16{a[15]}}, a[15:0]};
        3'd3:    r = {16'd0, a[15:0]};
        3'd4:    r = a;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [2:0]  req_size;
  logic [32:0] req_last;
  logic        req_in_range, req_misal, req_err, accept;
  logic [2:0]  size_q;
  logic        is_store;
  logic [1:0]  last_cnt;
  logic        active;
  logic [1:0]  sel;

  // Range check covers every byte of the access, in 33 bits so the window end cannot wrap.
  assign req_size     = op_size(bus.req_op);
  assign req_last     = {1'b0, bus.req_addr} + {30'd0, req_size} - 33'd1;
  assign req_in_range = ({1'b0, bus.req_addr} >= WIN_LO) && (req_last < WIN_HI);
  assign req_misal    = ((req_size == 3'd2) && bus.req_addr[0]) ||
                        ((req_size == 3'd4) && (bus.req_addr[1:0] != 2'b00));
  assign req_err      = !req_in_range || (req_misal && !ALLOW_MISALIGNED);
  assign accept       = (state_q == IDLE) && bus.req_valid && !rst_sig;

  assign size_q   = op_size(op_q);
  assign is_store = (op_q >= 3'd5);
  assign last_cnt = (size_q == 3'd4) ? 2'd3 : 2'd1;

  always_ff @(posedge clk_sig) begin
    if (rst_sig) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : (req_misal ? SPLIT : ACCESS);
      ACCESS:  state_d = RESP;
      SPLIT:   if (cnt_q == last_cnt) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    asm_d        = asm_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (accept) begin
      op_d    = bus.req_op;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      asm_d   = '0;
      cnt_d   = 2'd0;
      err_d   = req_err;
    end
    case (state_q)
      ACCESS: asm_d = bus.mem_rdata;
      SPLIT: begin
        asm_d[{cnt_q, 3'b000} +: 8] = bus.mem_rdata[7:0];
        cnt_d = cnt_q + 2'd1;
      end
      default: ;
    endcase
    // Response fields are frozen on entry to RESP and held until the next response.
    if ((state_d == RESP) && (state_q != RESP)) begin
      resp_rdata_d = extend(op_d, err_d, asm_d);
      resp_err_d   = err_d;
    end
  end

  always_ff @(posedge clk_sig) begin
    if (rst_sig) begin
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      asm_q        <= asm_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Reset blocks the memory port at once so an interrupted split commits nothing further.
  assign active = ((state_q == ACCESS) || (state_q == SPLIT)) && !rst_sig;

  always_comb begin
    if (state_q == SPLIT)      sel = 2'b11;
    else if (size_q == 3'd4)   sel = 2'b01;
    else if (size_q == 3'd2)   sel = 2'b10;
    else                       sel = 2'b11;
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE) && !rst_sig;
    bus.resp_valid = (state_q == RESP);
    bus.resp_rdata = resp_rdata_q;
    bus.resp_err   = resp_err_q;
    bus.mem_ena    = 1'b0;
    bus.mem_wr_en  = 1'b0;
    bus.mem_wr_sel = 2'b00;
    bus.mem_rd_sel = 2'b00;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (active) begin
      bus.mem_ena   = 1'b1;
      bus.mem_wr_en = is_store;
      bus.mem_addr  = (state_q == SPLIT) ? (addr_q + {30'd0, cnt_q}) : addr_q;
      if (is_store) begin
        bus.mem_wr_sel = sel;
        if (state_q == SPLIT)    bus.mem_wdata = {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]};
        else if (size_q == 3'd1) bus.mem_wdata = {24'd0, wdata_q[7:0]};
        else if (size_q == 3'd2) bus.mem_wdata = {16'd0, wdata_q[15:0]};
        else                     bus.mem_wdata = wdata_q;
      end else begin
        bus.mem_rd_sel = sel;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_requester.sv
// Bench for lsu_mem_requester: byte-array memory model, response scoreboard, vector table
// plus hand sequences for misaligned-disabled instance and reset in the middle of a split store.
module tb_lsu_mem_requester;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3, LW = 3'd4,
                         SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic clk_sig = 1'b0;
  logic rst_sig = 1'b1;
  always #5 clk_sig = ~clk_sig;

  lsu_mem_requester_if bus ();
  lsu_mem_requester_if bus2 ();

  lsu_mem_requester dut (.clk_sig(clk_sig), .rst_sig(rst_sig), .bus(bus));
  lsu_mem_requester #(.ALLOW_MISALIGNED(1'b0)) dut_na (.clk_sig(clk_sig), .rst_sig(rst_sig), .bus(bus2));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int ena2_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: data window of 4096 bytes, reads zero-extended per select.
  logic [7:0]  mem [0:4095] = '{default: 8'h00};
  logic [31:0] wr_off;

  function automatic logic [7:0] rd_byte(input logic [31:0] o);
    return (o < 32'd4096) ? mem[o[11:0]] : 8'h00;
  endfunction

  always_comb begin
    logic [31:0] o;
    o = bus.mem_addr - BASE;
    bus.mem_rdata = 32'h0;
    if (bus.mem_ena && !bus.mem_wr_en) begin
      case (bus.mem_rd_sel)
        2'b01: bus.mem_rdata = {rd_byte(o + 3), rd_byte(o + 2), rd_byte(o + 1), rd_byte(o)};
        2'b10: bus.mem_rdata = {16'h0, rd_byte(o + 1), rd_byte(o)};
        2'b11: bus.mem_rdata = {24'h0, rd_byte(o)};
        default: bus.mem_rdata = 32'h0;
      endcase
    end
  end

  always @(posedge clk_sig) begin
    if (bus.mem_ena && bus.mem_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if ((bus.mem_wr_sel == 2'b01) || (bus.mem_wr_sel == 2'b10 && i < 2) ||
            (bus.mem_wr_sel == 2'b11 && i < 1)) begin
          wr_off = bus.mem_addr - BASE + i;
          if (wr_off < 32'd4096) mem[wr_off[11:0]] <= bus.mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus2.mem_rdata = (bus2.mem_ena && bus2.mem_rd_sel == 2'b01) ? 32'h0BAD_F00D : 32'h0;

  always @(posedge clk_sig) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [1:0]  wsel;
    logic [1:0]  rsel;
  } acc_t;

  exp_t sb[$];
  acc_t log_q[$];

  always @(negedge clk_sig) begin
    exp_t e;
    if (bus2.mem_ena) ena2_cnt <= ena2_cnt + 1;
    if (bus.mem_ena)
      log_q.push_back('{bus.mem_addr, bus.mem_wdata, bus.mem_wr_en, bus.mem_wr_sel, bus.mem_rd_sel});
    if (bus.resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
        chk("resp_latency", cyc - e.acc_cyc, e.lat);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic err, input int lat, input bit score);
    int t;
    t = 0;
    @(posedge clk_sig); #1;
    while (!bus.req_ready && t < 50) begin
      @(posedge clk_sig); #1;
      t++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    log_q.delete();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    if (score) sb.push_back('{rdata, err, lat, cyc});
    @(posedge clk_sig); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk_sig); #1;
      t++;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  function automatic logic [1:0] sel_of(input logic [2:0] op, input bit split);
    if (split) return 2'b11;
    case (op)
      LW, SW:      return 2'b01;
      LH, LHU, SH: return 2'b10;
      default:     return 2'b11;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  initial begin
    vec_t        v;
    int          nacc;
    bit          split, is_st;
    acc_t        e;
    logic [31:0] exp_wd;

    vecs[0]  = '{SW,  BASE + 32'h004, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2};
    vecs[1]  = '{LW,  BASE + 32'h004, 32'h0,         32'hDEAD_BEEF, 1'b0, 2};
    vecs[2]  = '{SW,  BASE + 32'h004, 32'h8012_3456, 32'h0000_0000, 1'b0, 2};
    vecs[3]  = '{LB,  BASE + 32'h007, 32'h0,         32'hFFFF_FF80, 1'b0, 2};
    vecs[4]  = '{LBU, BASE + 32'h007, 32'h0,         32'h0000_0080, 1'b0, 2};
    vecs[5]  = '{LH,  BASE + 32'h006, 32'h0,         32'hFFFF_8012, 1'b0, 2};
    vecs[6]  = '{LHU, BASE + 32'h004, 32'h0,         32'h0000_3456, 1'b0, 2};
    vecs[7]  = '{LB,  BASE + 32'h004, 32'h0,         32'h0000_0056, 1'b0, 2};
    vecs[8]  = '{SW,  BASE + 32'h000, 32'h0,         32'h0000_0000, 1'b0, 2};
    vecs[9]  = '{SW,  BASE + 32'h004, 32'h0,         32'h0000_0000, 1'b0, 2};
    vecs[10] = '{SW,  BASE + 32'h003, 32'h1122_3344, 32'h0000_0000, 1'b0, 5};
    vecs[11] = '{LW,  BASE + 32'h004, 32'h0,         32'h0011_2233, 1'b0, 2};
    vecs[12] = '{LW,  BASE + 32'h003, 32'h0,         32'h1122_3344, 1'b0, 5};
    vecs[13] = '{LH,  BASE + 32'h005, 32'h0,         32'h0000_1122, 1'b0, 3};
    vecs[14] = '{SH,  BASE + 32'h001, 32'hFFFF_A5B6, 32'h0000_0000, 1'b0, 3};
    vecs[15] = '{LH,  BASE + 32'h001, 32'h0,         32'hFFFF_A5B6, 1'b0, 3};
    vecs[16] = '{LHU, BASE + 32'h001, 32'h0,         32'h0000_A5B6, 1'b0, 3};
    vecs[17] = '{SB,  BASE + 32'h000, 32'h1234_567F, 32'h0000_0000, 1'b0, 2};
    vecs[18] = '{LW,  BASE + 32'h000, 32'h0,         32'h44A5_B67F, 1'b0, 2};
    vecs[19] = '{LW,  32'h0000_0000,  32'h0,         32'h0000_0000, 1'b1, 1};
    vecs[20] = '{LW,  BASE + 32'hFFE, 32'h0,         32'h0000_0000, 1'b1, 1};
    vecs[21] = '{LW,  BASE + 32'hFFC, 32'h0,         32'h0000_0000, 1'b0, 2};
    vecs[22] = '{LB,  BASE + 32'h1000, 32'h0,        32'h0000_0000, 1'b1, 1};
    vecs[23] = '{LB,  BASE + 32'hFFF, 32'h0,         32'h0000_0000, 1'b0, 2};
    vecs[24] = '{LW,  BASE - 32'h004, 32'h0,         32'h0000_0000, 1'b1, 1};
    vecs[25] = '{SH,  BASE + 32'hFFF, 32'h0000_BEEF, 32'h0000_0000, 1'b1, 1};
    vecs[26] = '{LH,  BASE + 32'hFFE, 32'h0,         32'h0000_0000, 1'b0, 2};

    bus.req_valid  = 1'b0; bus.req_op  = 3'd0; bus.req_addr  = '0; bus.req_wdata  = '0;
    bus2.req_valid = 1'b0; bus2.req_op = 3'd0; bus2.req_addr = '0; bus2.req_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk_sig);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_mem_ena", {31'd0, bus.mem_ena}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    rst_sig = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      v     = vecs[i];
      nacc  = v.err ? 0 : v.lat - 1;
      split = (v.lat > 2);
      is_st = (v.op >= SB);
      issue(v.op, v.addr, v.wdata, v.rdata, v.err, v.lat, 1'b1);
      wait_idle();
      chk($sformatf("v%0d_access_count", i), log_q.size(), nacc);
      for (int j = 0; j < log_q.size() && j < nacc; j++) begin
        e = log_q[j];
        chk($sformatf("v%0d_b%0d_addr", i, j), e.addr, split ? v.addr + j : v.addr);
        chk($sformatf("v%0d_b%0d_wr_en", i, j), {31'd0, e.wr}, {31'd0, is_st});
        chk($sformatf("v%0d_b%0d_sel", i, j), {30'd0, is_st ? e.wsel : e.rsel},
            {30'd0, sel_of(v.op, split)});
        chk($sformatf("v%0d_b%0d_other_sel", i, j), {30'd0, is_st ? e.rsel : e.wsel}, 32'd0);
        if (is_st) begin
          if (split)           exp_wd = {24'd0, v.wdata[8*j +: 8]};
          else if (v.op == SB) exp_wd = {24'd0, v.wdata[7:0]};
          else if (v.op == SH) exp_wd = {16'd0, v.wdata[15:0]};
          else                 exp_wd = v.wdata;
          chk($sformatf("v%0d_b%0d_wdata", i, j), e.wdata, exp_wd);
        end
      end
      chk($sformatf("v%0d_rdata_hold", i), bus.resp_rdata, v.rdata);
      chk($sformatf("v%0d_err_hold", i), {31'd0, bus.resp_err}, {31'd0, v.err});
    end

    // Misaligned ops rejected when splitting is disabled
    @(posedge clk_sig); #1;
    chk("na_ready", {31'd0, bus2.req_ready}, 32'd1);
    bus2.req_valid = 1'b1; bus2.req_op = LH; bus2.req_addr = BASE + 32'h1;
    @(posedge clk_sig); #1;
    bus2.req_valid = 1'b0;
    chk("na_resp_valid", {31'd0, bus2.resp_valid}, 32'd1);
    chk("na_resp_err", {31'd0, bus2.resp_err}, 32'd1);
    chk("na_resp_rdata", bus2.resp_rdata, 32'd0);
    @(posedge clk_sig); #1;
    chk("na_resp_pulse", {31'd0, bus2.resp_valid}, 32'd0);
    chk("na_no_mem_ena", ena2_cnt, 32'd0);
    bus2.req_valid = 1'b1; bus2.req_op = LW; bus2.req_addr = BASE + 32'h4;
    @(posedge clk_sig); #1;
    bus2.req_valid = 1'b0;
    chk("na_lw_ena", {31'd0, bus2.mem_ena}, 32'd1);
    chk("na_lw_rd_sel", {30'd0, bus2.mem_rd_sel}, 32'd1);
    chk("na_lw_addr", bus2.mem_addr, BASE + 32'h4);
    @(posedge clk_sig); #1;
    chk("na_lw_valid", {31'd0, bus2.resp_valid}, 32'd1);
    chk("na_lw_rdata", bus2.resp_rdata, 32'h0BAD_F00D);
    chk("na_lw_err", {31'd0, bus2.resp_err}, 32'd0);

    // Reset during the third byte of a split store
    issue(SW, BASE + 32'h200, 32'hAAAA_AAAA, 32'h0, 1'b0, 2, 1'b1);
    wait_idle();
    issue(SW, BASE + 32'h204, 32'hAAAA_AAAA, 32'h0, 1'b0, 2, 1'b1);
    wait_idle();
    issue(SW, BASE + 32'h201, 32'hCAFE_F00D, 32'h0, 1'b0, 5, 1'b0);
    @(posedge clk_sig); #1;
    @(posedge clk_sig); #1;
    chk("rst_mid_byte2_ena", {31'd0, bus.mem_ena}, 32'd1);
    chk("rst_mid_byte2_addr", bus.mem_addr, BASE + 32'h203);
    rst_sig = 1'b1;
    @(posedge clk_sig); #1;
    chk("rst_mid_mem_ena", {31'd0, bus.mem_ena}, 32'd0);
    chk("rst_mid_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd0);
    rst_sig = 1'b0;
    #1;
    chk("rst_mid_ready_after", {31'd0, bus.req_ready}, 32'd1);
    repeat (6) @(posedge clk_sig);
    #1;
    issue(LW, BASE + 32'h200, 32'h0, 32'hAAF0_0DAA, 1'b0, 2, 1'b1);
    wait_idle();
    issue(LW, BASE + 32'h204, 32'h0, 32'hAAAA_AAAA, 1'b0, 2, 1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_requester.md
Name: lsu_mem_requester

Overview:
- CPU-side load/store initiator that drives the data-memory port and returns load data to the pipeline.
- Accepts one load/store op per handshake from the MEM stage.
- Aligned ops issue one memory access using the memory's word, half or byte select.
- Misaligned ops are split into sequential byte accesses (little-endian). Load results are sign- or zero-extended before return.

Parameters:
- MEM_BASE, 32'h10010000, byte address of data-memory word 0.
- MEM_BYTES, 4096, size of the valid data window in bytes. Valid range is MEM_BASE to MEM_BASE+MEM_BYTES-1.
- ALLOW_MISALIGNED, 1, 1 = split misaligned ops into byte accesses; 0 = flag them as errors.

Ports:
- clk_sig  input  1  clock, rising edge
- rst_sig  input  1  synchronous reset, active-high
- req_valid  input  1  op request valid
- req_ready  output  1  unit idle and able to accept
- req_op  input  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW
- req_addr  input  32  byte address
- req_wdata  input  32  store data; the low 8/16/32 bits are used
- resp_valid  output  1  one-cycle completion pulse (loads and stores)
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  valid with resp_valid; set for out-of-range, or misaligned when ALLOW_MISALIGNED=0
- mem_ena  output  1  memory enable
- mem_wr_en  output  1  1 = write, 0 = read
- mem_wr_sel  output  2  01 word, 10 half, 11 byte, 00 none
- mem_rd_sel  output  2  same encoding as mem_wr_sel
- mem_addr  output  32  byte address to memory
- mem_wdata  output  32  write data; byte/half data in the low bits
- mem_rdata  input  32  combinational read data; byte/half data zero-extended in the low bits

Behaviour:
- Reset: synchronous, active-high. While rst_sig=1 at a clock edge, all outputs go to 0 (including req_ready) and the FSM goes to IDLE.
- States: IDLE, ACCESS, SPLIT, RESP.
- No combinational path from req_* to mem_*. mem_* are decoded from registered state, address and data. All mem_* are 0 outside ACCESS and SPLIT.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch op, addr and wdata, clear the byte counter and the assembly register.
  - Next state is RESP with err=1 if the address (or any byte of the access) is out of range, or if the op is misaligned and ALLOW_MISALIGNED=0.
  - Otherwise next state is SPLIT if misaligned (half with addr[0]=1, word with addr[1:0]!=0), else ACCESS.
- ACCESS (1 cycle):
  - mem_ena=1. mem_wr_en=1 for stores.
  - Select: LW/SW = 01, LH/LHU/SH = 10, byte ops = 11. Only the matching sel is nonzero.
  - mem_addr is the latched address.
  - mem_rdata is captured into the assembly register at the closing edge. Next state RESP.
- SPLIT (N cycles, N=2 for half, 4 for word):
  - Byte i (i=0..N-1): mem_addr=addr+i, select 11, mem_wdata={24'b0, wdata[8i+7:8i]}.
  - For loads, mem_rdata[7:0] is captured into assembly[8i+7:8i].
  - Counter increments each cycle. Go to RESP after byte N-1.
  - Addresses may cross word boundaries.
- RESP (1 cycle):
  - resp_valid=1, req_ready=0.
  - resp_rdata: LB = sign-extend assembly[7:0]; LBU = zero-extend; LH = sign-extend assembly[15:0]; LHU = zero-extend; LW = as is.
  - Stores and errors return 0.
  - Next state IDLE.
- Latency from accept edge to resp_valid cycle:
  - aligned: 2 cycles
  - misaligned: N+1 cycles
  - error: 1 cycle
- Throughput: the next request is accepted in the IDLE cycle after RESP, i.e. one aligned op per 3 cycles.
- Reset mid-operation:
  - mem_ena=0 from the next cycle and no resp_valid is issued.
  - Byte writes already committed remain in memory.
- resp_rdata and resp_err hold their values outside resp_valid; consumers qualify them with resp_valid.

Test Plan:
1. Word at 0x10010004 preloaded 0xDEADBEEF; LW 0x10010004.
   -> one mem_ena cycle with rd_sel=01 and addr 0x10010004; resp_valid 2 cycles after accept with rdata 0xDEADBEEF, err=0.
2. Word at 0x10010004 = 0x80123456; LB 0x10010007 then LBU 0x10010007.
   -> rd_sel=11; rdata 0xFFFFFF80, then 0x00000080.
3. Memory zeroed, ALLOW_MISALIGNED=1; SW 0x11223344 to 0x10010003.
   -> four byte writes to 0x10010003..06 with data 0x44, 0x33, 0x22, 0x11; resp_valid 5 cycles after accept, rdata 0.
   -> a following LW 0x10010004 returns 0x00112233.
4. ALLOW_MISALIGNED=0; LH 0x10010001.
   -> mem_ena never asserted; resp_valid 1 cycle after accept with err=1, rdata 0.
5. LW 0x00000000, and LW MEM_BASE+MEM_BYTES-2 (partly out of range).
   -> each returns err=1 with no memory access.
6. rst_sig asserted during the 3rd byte of a misaligned SW.
   -> mem_ena=0 the next cycle; no resp_valid; bytes 0 and 1 written, bytes 2 and 3 unchanged; req_ready=1 in the first cycle after reset deasserts.
